// File: rtl/bp_update_scheduler_pkg.sv
// Shared types and defaults for the branch-predictor update scheduler.
// The entry payload is the training tuple handed to the predictor's update port.
package bp_update_scheduler_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned BP_UPD_DEPTH = 8;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            taken;
        logic [XLEN-1:0] target;
    } bp_upd_entry_t;

endpackage

// File: rtl/bp_update_scheduler_if.sv
// ROB-side retire inputs, predictor-side update handshake and status counters.
// The slave modport is the scheduler's view; the master modport drives it.
interface bp_update_scheduler_if
    import bp_update_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = BP_UPD_DEPTH
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic            in0_valid;
    logic [XLEN-1:0] in0_pc;
    logic            in0_taken;
    logic [XLEN-1:0] in0_target;
    logic            in1_valid;
    logic [XLEN-1:0] in1_pc;
    logic            in1_taken;
    logic [XLEN-1:0] in1_target;
    logic            in_ready;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_ready;
    logic [CNT_W-1:0] count;
    logic [15:0]     drop_cnt;

    modport slave (
        input  in0_valid, in0_pc, in0_taken, in0_target,
        input  in1_valid, in1_pc, in1_taken, in1_target,
        input  upd_ready,
        output in_ready, upd_valid, upd_pc, upd_taken, upd_target,
        output count, drop_cnt
    );

    modport master (
        output in0_valid, in0_pc, in0_taken, in0_target,
        output in1_valid, in1_pc, in1_taken, in1_target,
        output upd_ready,
        input  in_ready, upd_valid, upd_pc, upd_taken, upd_target,
        input  count, drop_cnt
    );

endinterface

// File: rtl/bp_update_scheduler_fifo.sv
// bp_upd_fifo: 2-write / 1-read circular buffer with occupancy count.
// push_n entries are written at tail (push0) and tail+1 (push1); the caller
// guarantees there is room and never pops an empty buffer.
module bp_upd_fifo
    import bp_update_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = BP_UPD_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             push_n,
    input  bp_upd_entry_t          push0,
    input  bp_upd_entry_t          push1,
    input  logic                   pop,
    output bp_upd_entry_t          head,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] count_next
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    bp_upd_entry_t    mem_q [DEPTH];
    bp_upd_entry_t    mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_n != 2'd0) begin
            mem_d[tail_q] = push0;
        end
        if (push_n == 2'd2) begin
            mem_d[tail_q + PTR_W'(1)] = push1;
        end
        tail_d = tail_q + PTR_W'(push_n);
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_n) - CNT_W'(pop);
    end

    // State registers; reset empties the buffer without draining it
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head       = mem_q[head_q];
    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler: funnels up to two retiring branch updates per cycle
// into the predictor's single in-order update port through bp_upd_fifo.
// Optional zero-latency bypass of an empty queue: define BP_UPD_BYPASS_EN.
module bp_update_scheduler
    import bp_update_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = BP_UPD_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    bp_update_scheduler_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    bp_upd_entry_t    in0_e, in1_e, push0, push1, fifo_head, upd_e;
    logic [1:0]       push_n;
    logic             pop, any_in, accept, fifo_nonempty;
    logic             byp_active, byp_take, upd_valid_c;
    logic [CNT_W-1:0] fifo_count, fifo_count_next;
    logic             in_ready_q, in_ready_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_n     (push_n),
        .push0      (push0),
        .push1      (push1),
        .pop        (pop),
        .head       (fifo_head),
        .count      (fifo_count),
        .count_next (fifo_count_next)
    );

    // Enqueue selection, pop, bypass, output mux and drop accounting
    always_comb begin
        in0_e         = '{pc: bus.in0_pc, taken: bus.in0_taken, target: bus.in0_target};
        in1_e         = '{pc: bus.in1_pc, taken: bus.in1_taken, target: bus.in1_target};
        fifo_nonempty = (fifo_count != '0);
        any_in        = bus.in0_valid | bus.in1_valid;
        accept        = any_in & in_ready_q;
        byp_active    = 1'b0;
        byp_take      = 1'b0;
        push_n        = 2'd0;
        push0         = in0_e;
        push1         = in1_e;
        upd_e         = '0;
        drop_cnt_d    = drop_cnt_q;

`ifdef BP_UPD_BYPASS_EN
        byp_active = ~fifo_nonempty & in_ready_q & any_in;
        byp_take   = byp_active & bus.upd_ready;
`endif

        // The oldest valid input is the one bypassed; only the younger is queued then
        if (accept) begin
            if (bus.in0_valid && bus.in1_valid) begin
                if (byp_take) begin
                    push_n = 2'd1;
                    push0  = in1_e;
                end else begin
                    push_n = 2'd2;
                end
            end else if (!byp_take) begin
                push_n = 2'd1;
                push0  = bus.in0_valid ? in0_e : in1_e;
            end
        end

        pop         = fifo_nonempty & bus.upd_ready;
        upd_valid_c = fifo_nonempty | byp_active;
        if (fifo_nonempty) begin
            upd_e = fifo_head;
        end else if (byp_active) begin
            upd_e = bus.in0_valid ? in0_e : in1_e;
        end

        if (any_in && !in_ready_q && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // in_ready reflects room for a full pair after this cycle's push/pop
    always_comb begin
        in_ready_d = (CNT_W'(DEPTH) - fifo_count_next) >= CNT_W'(2);
    end

    // Status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_q <= 1'b1;
            drop_cnt_q <= '0;
        end else begin
            in_ready_q <= in_ready_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.drop_cnt   = drop_cnt_q;
    assign bus.count      = fifo_count;
    assign bus.upd_valid  = upd_valid_c;
    assign bus.upd_pc     = upd_e.pc;
    assign bus.upd_taken  = upd_e.taken;
    assign bus.upd_target = upd_e.target;

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Bench for bp_update_scheduler: directed vector table plus randomized traffic
// against a queue-based reference model of the update stream.
module tb_bp_update_scheduler;
    import bp_update_scheduler_pkg::*;

    localparam int unsigned DEPTH = 8;
`ifdef BP_UPD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    bp_update_scheduler_if #(.DEPTH(DEPTH)) bus ();

    bp_update_scheduler #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          v0;
        logic [31:0] pc0;
        bit          v1;
        logic [31:0] pc1;
        bit          rdy;
        bit          e_valid;
        logic [31:0] e_pc;
        int unsigned e_count;
        bit          e_in_ready;
        int unsigned e_drop;
    } vec_t;

    vec_t tbl[18];

    // Reference model: queue of pending updates, registered in_ready, drop count
    bp_upd_entry_t mq[$];
    int unsigned   m_drop;
    bit            m_rdy;
    logic [31:0]   pc_ctr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bp_upd_entry_t ent(input logic [31:0] pc);
        bp_upd_entry_t e;
        e.pc     = pc;
        e.taken  = pc[2] ^ pc[8];
        e.target = pc + 32'h100;
        return e;
    endfunction

    function automatic vec_t mkv(input bit v0, input logic [31:0] pc0, input bit v1,
                                 input logic [31:0] pc1, input bit rdy, input bit ev,
                                 input logic [31:0] epc, input int unsigned ecnt,
                                 input bit erdy, input int unsigned edrop);
        vec_t v;
        v.v0 = v0; v.pc0 = pc0; v.v1 = v1; v.pc1 = pc1; v.rdy = rdy;
        v.e_valid = ev; v.e_pc = epc; v.e_count = ecnt; v.e_in_ready = erdy; v.e_drop = edrop;
        return v;
    endfunction

    task automatic drive(input bit v0, input logic [31:0] pc0, input bit v1,
                         input logic [31:0] pc1, input bit rdy);
        bp_upd_entry_t e0, e1;
        e0 = ent(pc0);
        e1 = ent(pc1);
        bus.in0_valid  = v0;
        bus.in0_pc     = pc0;
        bus.in0_taken  = e0.taken;
        bus.in0_target = e0.target;
        bus.in1_valid  = v1;
        bus.in1_pc     = pc1;
        bus.in1_taken  = e1.taken;
        bus.in1_target = e1.target;
        bus.upd_ready  = rdy;
    endtask

    task automatic drive_rand(input bit v0, input bit v1, input bit rdy);
        bus.in0_valid  = v0;
        bus.in0_pc     = pc_ctr;
        bus.in0_taken  = 1'($urandom_range(0, 1));
        bus.in0_target = $urandom;
        bus.in1_valid  = v1;
        bus.in1_pc     = pc_ctr + 32'd4;
        bus.in1_taken  = 1'($urandom_range(0, 1));
        bus.in1_target = $urandom;
        bus.upd_ready  = rdy;
        pc_ctr         = pc_ctr + 32'd8;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        m_drop = 0;
        m_rdy  = 1'b1;
    endtask

    function automatic bp_upd_entry_t in_entry(input bit sel1);
        bp_upd_entry_t e;
        e.pc     = sel1 ? bus.in1_pc     : bus.in0_pc;
        e.taken  = sel1 ? bus.in1_taken  : bus.in0_taken;
        e.target = sel1 ? bus.in1_target : bus.in0_target;
        return e;
    endfunction

    task automatic model_check();
        bp_upd_entry_t e;
        bit ev;
        ev = 1'b0;
        e  = '0;
        if (mq.size() > 0) begin
            ev = 1'b1;
            e  = mq[0];
        end else if (BYP && m_rdy && (bus.in0_valid || bus.in1_valid)) begin
            ev = 1'b1;
            e  = in_entry(!bus.in0_valid);
        end
        chk("m_upd_valid",  64'(bus.upd_valid),  64'(ev));
        chk("m_upd_pc",     64'(bus.upd_pc),     64'(e.pc));
        chk("m_upd_taken",  64'(bus.upd_taken),  64'(e.taken));
        chk("m_upd_target", 64'(bus.upd_target), 64'(e.target));
        chk("m_count",      64'(bus.count),      64'(mq.size()));
        chk("m_in_ready",   64'(bus.in_ready),   64'(m_rdy));
        chk("m_drop_cnt",   64'(bus.drop_cnt),   64'(m_drop));
    endtask

    task automatic model_step();
        bit any, take;
        int unsigned sz;
        sz   = mq.size();
        any  = bus.in0_valid | bus.in1_valid;
        take = BYP && sz == 0 && m_rdy && any && bus.upd_ready;
        if (sz > 0 && bus.upd_ready) void'(mq.pop_front());
        if (any) begin
            if (m_rdy) begin
                if (bus.in0_valid && !take) mq.push_back(in_entry(1'b0));
                if (bus.in1_valid && !(take && !bus.in0_valid)) mq.push_back(in_entry(1'b1));
            end else if (m_drop < 65535) begin
                m_drop++;
            end
        end
        m_rdy = (int'(DEPTH) - mq.size()) >= 2;
    endtask

    task automatic model_cycle();
        #1;
        model_check();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        bp_upd_entry_t ee;
        reset  = 1'b1;
        pc_ctr = 32'h1000;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        do_reset();

        // Reset state
        #1;
        chk("rst_count",     64'(bus.count),     64'(0));
        chk("rst_upd_valid", 64'(bus.upd_valid), 64'(0));
        chk("rst_upd_pc",    64'(bus.upd_pc),    64'(0));
        chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
        chk("rst_drop_cnt",  64'(bus.drop_cnt),  64'(0));
        @(negedge clk);

`ifndef BP_UPD_BYPASS_EN
        // Directed table: single, pair, fill to full, drops, full-with-pop, in1 alone
        tbl[0]  = mkv(1, 32'h100, 0, 32'h0,  1, 0, 32'h0,  0, 1, 0);
        tbl[1]  = mkv(0, 32'h0,   0, 32'h0,  1, 1, 32'h100, 1, 1, 0);
        tbl[2]  = mkv(1, 32'h10,  1, 32'h14, 1, 0, 32'h0,  0, 1, 0);
        tbl[3]  = mkv(0, 32'h0,   0, 32'h0,  1, 1, 32'h10, 2, 1, 0);
        tbl[4]  = mkv(0, 32'h0,   0, 32'h0,  1, 1, 32'h14, 1, 1, 0);
        tbl[5]  = mkv(1, 32'h20,  1, 32'h24, 0, 0, 32'h0,  0, 1, 0);
        tbl[6]  = mkv(1, 32'h28,  1, 32'h2c, 0, 1, 32'h20, 2, 1, 0);
        tbl[7]  = mkv(1, 32'h30,  1, 32'h34, 0, 1, 32'h20, 4, 1, 0);
        tbl[8]  = mkv(1, 32'h38,  1, 32'h3c, 0, 1, 32'h20, 6, 1, 0);
        tbl[9]  = mkv(1, 32'h40,  0, 32'h0,  0, 1, 32'h20, 8, 0, 0);
        tbl[10] = mkv(1, 32'h44,  0, 32'h0,  0, 1, 32'h20, 8, 0, 1);
        tbl[11] = mkv(1, 32'h48,  0, 32'h0,  0, 1, 32'h20, 8, 0, 2);
        tbl[12] = mkv(0, 32'h0,   0, 32'h0,  0, 1, 32'h20, 8, 0, 3);
        tbl[13] = mkv(1, 32'h4c,  0, 32'h0,  1, 1, 32'h20, 8, 0, 3);
        tbl[14] = mkv(1, 32'h50,  0, 32'h0,  1, 1, 32'h24, 7, 0, 4);
        tbl[15] = mkv(0, 32'h0,   0, 32'h0,  1, 1, 32'h28, 6, 1, 5);
        tbl[16] = mkv(0, 32'h0,   1, 32'h60, 0, 1, 32'h2c, 5, 1, 5);
        tbl[17] = mkv(0, 32'h0,   0, 32'h0,  1, 1, 32'h2c, 6, 1, 5);
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].v0, tbl[i].pc0, tbl[i].v1, tbl[i].pc1, tbl[i].rdy);
            #1;
            ee = tbl[i].e_valid ? ent(tbl[i].e_pc) : '0;
            chk($sformatf("t%0d_upd_valid", i),  64'(bus.upd_valid),  64'(tbl[i].e_valid));
            chk($sformatf("t%0d_upd_pc", i),     64'(bus.upd_pc),     64'(ee.pc));
            chk($sformatf("t%0d_upd_taken", i),  64'(bus.upd_taken),  64'(ee.taken));
            chk($sformatf("t%0d_upd_target", i), 64'(bus.upd_target), 64'(ee.target));
            chk($sformatf("t%0d_count", i),      64'(bus.count),      64'(tbl[i].e_count));
            chk($sformatf("t%0d_in_ready", i),   64'(bus.in_ready),   64'(tbl[i].e_in_ready));
            chk($sformatf("t%0d_drop_cnt", i),   64'(bus.drop_cnt),   64'(tbl[i].e_drop));
            @(posedge clk);
            @(negedge clk);
        end
        do_reset();
`endif

        // 20 single updates with random upd_ready, then drain
        for (int i = 0; i < 20; i++) begin
            drive_rand(1'b1, 1'b0, 1'($urandom_range(0, 1)));
            model_cycle();
        end
        for (int i = 0; i < 30; i++) begin
            drive_rand(1'b0, 1'b0, 1'($urandom_range(0, 3) != 0));
            model_cycle();
        end

        // Mixed random traffic including pairs, in1-only, back-pressure and drops
        for (int i = 0; i < 400; i++) begin
            drive_rand(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
                       1'($urandom_range(0, 1)));
            model_cycle();
        end

        // Reset with five entries queued
        do_reset();
        drive_rand(1'b1, 1'b1, 1'b0); model_cycle();
        drive_rand(1'b1, 1'b1, 1'b0); model_cycle();
        drive_rand(1'b0, 1'b1, 1'b0); model_cycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("pre_rst_count", 64'(bus.count), 64'(5));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_count",     64'(bus.count),     64'(0));
        chk("mid_rst_upd_valid", 64'(bus.upd_valid), 64'(0));
        chk("mid_rst_upd_pc",    64'(bus.upd_pc),    64'(0));
        chk("mid_rst_in_ready",  64'(bus.in_ready),  64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
